mc_delay_ctrl: RTL and testbench
================================

MC_DELAY_CTRL -- requirements
Module: mc_delay_ctrl

Interface
REQ-001 SHALL have parameter NumDelayBits, default 4, giving the width of the delay-select code driven to the delay line.
REQ-002 SHALL have parameter SettleCycles, default 4, giving the cycles delay_o is held after each step; legal range is 1..255.
REQ-003 SHALL have parameter ResetDelay, default 0, giving the delay code applied at reset.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port tgt_valid_i, input, 1 bit: a new target delay code is offered.
REQ-007 SHALL have port tgt_ready_o, output, 1 bit: the controller accepts a target.
REQ-008 SHALL have port tgt_delay_i, input, NumDelayBits: the target delay code.
REQ-009 SHALL have port delay_o, output, NumDelayBits: registered select code to the delay line delay_i.
REQ-010 SHALL have port busy_o, output, 1 bit: the controller is walking toward a target.
REQ-011 SHALL have port done_o, output, 1 bit: one-cycle pulse when delay_o has reached the accepted target.

Function
REQ-012 SHALL implement FSM states IDLE, STEP and SETTLE.
REQ-013 SHALL drive tgt_ready_o=1 only in IDLE, so a target is accepted on an edge where tgt_valid_i and tgt_ready_o are both 1.
REQ-014 On acceptance, SHALL register tgt_delay_i into an internal target register and go IDLE->STEP.
REQ-015 In STEP with delay_o != target, SHALL move delay_o by exactly +1 (delay_o<target) or -1 (delay_o>target), load the settle counter with SettleCycles-1, and go to SETTLE.
REQ-016 In STEP with delay_o == target, SHALL leave delay_o unchanged, go to IDLE, and assert done_o for the following cycle.
REQ-017 In SETTLE, SHALL decrement the counter each edge; at the edge where the counter is 0, SHALL go to STEP if delay_o != target, otherwise go to IDLE and assert done_o for the following cycle.
REQ-018 SHALL give each step a cost of SettleCycles+1 edges, so N steps from acceptance edge E0 reach IDLE at edge E0+N*(SettleCycles+1), with done_o high in the cycle after that edge.
REQ-019 SHALL never let delay_o wrap around: codes stay within 0..2^NumDelayBits-1 and the step direction is chosen by unsigned compare.
REQ-020 SHALL change delay_o only in STEP, and by at most one code per step.
REQ-021 SHALL drive busy_o=1 in STEP and SETTLE and 0 in IDLE.
REQ-022 SHALL keep done_o high for exactly one cycle per accepted target, including a zero-step target.
REQ-023 SHALL ignore tgt_valid_i while busy, and SHALL not sample tgt_delay_i outside acceptance.
REQ-024 A new target offered in the same cycle done_o is high SHALL be accepted, because the FSM is already in IDLE.

Reset
REQ-025 While rst_i=1, SHALL hold delay_o=ResetDelay, target=ResetDelay, FSM=IDLE, counter=0, done_o=0, busy_o=0 and tgt_ready_o=1.
REQ-026 Reset asserted mid-walk SHALL abandon the target immediately (asynchronously) and emit no done_o.

Structure
REQ-027 SHALL place the FSM state enum and the default delay width constant in the shared package mc_delay_pkg.
REQ-028 SHALL be a single module with no sub-modules; the settle counter is inline, sized to $clog2(SettleCycles+1) with a minimum of 1 bit.
REQ-029 SHALL connect delay_o directly to delay_line_D4_O1_6P000.delay_i without added logic.

Verification
REQ-030 Reset: assert rst_i mid-cycle -> delay_o=0, tgt_ready_o=1, busy_o=0 and done_o=0 immediately, before the next edge.
REQ-031 Up-walk, S=4: from 0, accept target 5 at E0 -> delay_o = 1,2,3,4,5 at edges E0+1, +6, +11, +16, +21; done_o high after edge E0+25 for one cycle.
REQ-032 Down-walk: from 5, accept target 2 -> delay_o = 4,3,2, each held 5 cycles; done_o after 15 edges.
REQ-033 Zero-step: from 7, accept target 7 -> delay_o unchanged; done_o high the cycle after edge E0+1.
REQ-034 Busy/back-to-back: tgt_valid_i=1 with 9 while walking to 3 -> 9 ignored and delay_o stops at 3; 9 offered while done_o=1 -> accepted on that edge.
REQ-035 Corners: target 15 from 0 -> delay_o reaches 15 without wrap; rst_i at delay_o=6 mid-SETTLE -> delay_o=0 and no done_o.

Source files
------------

// File: rtl/mc_delay_pkg.sv
// Shared types and constants for the delay-line step controller.
package mc_delay_pkg;

    localparam int DefaultDelayBits = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/mc_delay_ctrl.sv
// Walks a delay-line select code one step at a time toward an accepted target,
// holding each intermediate code for a settle interval before the next step.
module mc_delay_ctrl
    import mc_delay_pkg::*;
#(
    parameter int NumDelayBits = DefaultDelayBits,
    parameter int SettleCycles = 4,
    parameter int ResetDelay   = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    tgt_valid_i,
    output logic                    tgt_ready_o,
    input  logic [NumDelayBits-1:0] tgt_delay_i,
    output logic [NumDelayBits-1:0] delay_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int CntW = ($clog2(SettleCycles + 1) > 1) ? $clog2(SettleCycles + 1) : 1;
    localparam logic [CntW-1:0]         CntLoad   = CntW'(SettleCycles - 1);
    localparam logic [NumDelayBits-1:0] ResetCode = NumDelayBits'(ResetDelay);

    state_e                  state_q, state_d;
    logic [NumDelayBits-1:0] delay_q, delay_d;
    logic [NumDelayBits-1:0] tgt_q,   tgt_d;
    logic [CntW-1:0]         cnt_q,   cnt_d;
    logic                    done_q,  done_d;

    // State, code, target, settle counter and done pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            delay_q <= ResetCode;
            tgt_q   <= ResetCode;
            cnt_q   <= {CntW{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; the code only moves in STEP and saturation is implied
    // because a step is never taken once the code equals the target.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tgt_valid_i) begin
                    tgt_d   = tgt_delay_i;
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (delay_q < tgt_q) begin
                    delay_d = delay_q + NumDelayBits'(1);
                    cnt_d   = CntLoad;
                    state_d = ST_SETTLE;
                end else if (delay_q > tgt_q) begin
                    delay_d = delay_q - NumDelayBits'(1);
                    cnt_d   = CntLoad;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != {CntW{1'b0}}) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (delay_q != tgt_q) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CntW{1'b0}};
            end
        endcase
    end

    assign delay_o     = delay_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign tgt_ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mc_delay_ctrl.sv
// Self-checking bench for mc_delay_ctrl: directed scenarios plus random targets
// checked against a timing model derived from the step-cost arithmetic.
module tb_mc_delay_ctrl;

    localparam int S = 4;

    logic       clk_i;
    logic       rst_i;
    logic       tgt_valid_i;
    logic       tgt_ready_o;
    logic [3:0] tgt_delay_i;
    logic [3:0] delay_o;
    logic       busy_o;
    logic       done_o;

    int compared;
    int mismatched;
    int model_delay;

    mc_delay_ctrl #(
        .NumDelayBits(4),
        .SettleCycles(S),
        .ResetDelay  (0)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tgt_valid_i(tgt_valid_i),
        .tgt_ready_o(tgt_ready_o),
        .tgt_delay_i(tgt_delay_i),
        .delay_o    (delay_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Offer tgt at the current negedge, then follow every edge until done_o.
    // noise: 0 = valid low while busy, 1 = random offers, 2 = constant offer of 9.
    task automatic walk(input int tgt, input int noise, input string name);
        int n;
        int done_k;
        int steps;
        logic [3:0] exp_d;
        n      = (tgt > model_delay) ? tgt - model_delay : model_delay - tgt;
        done_k = (n == 0) ? 1 : n * (S + 1);
        compared++;
        if (tgt_ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL %s ready_at_offer got %b expected 1", name, tgt_ready_o);
        end
        tgt_valid_i = 1'b1;
        tgt_delay_i = 4'(tgt);
        for (int k = 0; k <= done_k; k++) begin
            @(negedge clk_i);
            steps = (k == 0) ? 0 : ((k - 1) / (S + 1) + 1);
            if (steps > n) steps = n;
            exp_d = (tgt >= model_delay) ? 4'(model_delay + steps) : 4'(model_delay - steps);
            compared++;
            if (delay_o !== exp_d) begin
                mismatched++;
                $display("FAIL %s delay k=%0d got %0d expected %0d", name, k, delay_o, exp_d);
            end
            compared++;
            if (busy_o !== (k < done_k)) begin
                mismatched++;
                $display("FAIL %s busy k=%0d got %b expected %b", name, k, busy_o, (k < done_k));
            end
            compared++;
            if (tgt_ready_o !== (k >= done_k)) begin
                mismatched++;
                $display("FAIL %s ready k=%0d got %b expected %b", name, k, tgt_ready_o, (k >= done_k));
            end
            compared++;
            if (done_o !== (k == done_k)) begin
                mismatched++;
                $display("FAIL %s done k=%0d got %b expected %b", name, k, done_o, (k == done_k));
            end
            if (k < done_k && noise == 1) begin
                tgt_valid_i = 1'($urandom_range(0, 1));
                tgt_delay_i = 4'($urandom_range(0, 15));
            end else if (k < done_k && noise == 2) begin
                tgt_valid_i = 1'b1;
                tgt_delay_i = 4'd9;
            end else begin
                tgt_valid_i = 1'b0;
                tgt_delay_i = 4'($urandom_range(0, 15));
            end
        end
        model_delay = tgt;
    endtask

    // One idle cycle after a walk: done must have dropped, code must hold.
    task automatic idle_cycle(input string name);
        @(negedge clk_i);
        compared++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || delay_o !== 4'(model_delay)) begin
            mismatched++;
            $display("FAIL %s idle got done=%b busy=%b delay=%0d expected 0 0 %0d",
                     name, done_o, busy_o, delay_o, model_delay);
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        tgt_valid_i = 1'b0;
        tgt_delay_i = 4'd0;
        #3;
        compared++;
        if (delay_o !== 4'd0 || tgt_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_async got delay=%0d ready=%b busy=%b done=%b expected 0 1 0 0",
                     delay_o, tgt_ready_o, busy_o, done_o);
        end
        tgt_valid_i = 1'b1;
        tgt_delay_i = 4'd12;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        compared++;
        if (delay_o !== 4'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_held got delay=%0d busy=%b done=%b expected 0 0 0",
                     delay_o, busy_o, done_o);
        end
        tgt_valid_i = 1'b0;
        rst_i       = 1'b0;
        model_delay = 0;
        idle_cycle("reset_release");
    endtask

    task automatic test_up_walk();
        walk(5, 0, "up_walk");
        idle_cycle("up_walk_after");
    endtask

    task automatic test_down_walk();
        walk(2, 0, "down_walk");
        idle_cycle("down_walk_after");
    endtask

    task automatic test_zero_step();
        walk(7, 0, "zero_setup");
        idle_cycle("zero_setup_after");
        walk(7, 0, "zero_step");
        idle_cycle("zero_step_after");
    endtask

    task automatic test_back_to_back();
        walk(3, 2, "busy_ignore");
        walk(9, 0, "accept_on_done");
        walk(9, 1, "zero_on_done");
        idle_cycle("back_to_back_after");
    endtask

    task automatic test_corner_wrap();
        walk(0, 1, "to_zero");
        walk(15, 1, "to_fifteen");
        walk(15, 0, "fifteen_zero_step");
        walk(0, 0, "fifteen_to_zero");
        idle_cycle("corner_after");
    endtask

    task automatic test_random();
        int gap;
        for (int i = 0; i < 12; i++) begin
            walk($urandom_range(0, 15), $urandom_range(0, 2) == 0 ? 0 : 1, "random");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle("random_gap");
        end
    endtask

    task automatic test_reset_mid_walk();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i       = 1'b0;
        model_delay = 0;
        tgt_valid_i = 1'b1;
        tgt_delay_i = 4'd15;
        // code 6 is reached at edge E0+26; E0+28 is two edges into its settle
        for (int k = 0; k <= 28; k++) begin
            @(negedge clk_i);
            tgt_valid_i = 1'b0;
        end
        compared++;
        if (delay_o !== 4'd6 || busy_o !== 1'b1) begin
            mismatched++;
            $display("FAIL midwalk_pre got delay=%0d busy=%b expected 6 1", delay_o, busy_o);
        end
        #2 rst_i = 1'b1;
        #1;
        compared++;
        if (delay_o !== 4'd0 || tgt_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            mismatched++;
            $display("FAIL midwalk_reset got delay=%0d ready=%b busy=%b done=%b expected 0 1 0 0",
                     delay_o, tgt_ready_o, busy_o, done_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            compared++;
            if (done_o !== 1'b0 || delay_o !== 4'd0 || busy_o !== 1'b0) begin
                mismatched++;
                $display("FAIL midwalk_after k=%0d got done=%b delay=%0d busy=%b expected 0 0 0",
                         k, done_o, delay_o, busy_o);
            end
        end
        walk(4, 0, "after_midwalk");
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        model_delay = 0;
        test_reset();
        test_up_walk();
        test_down_walk();
        test_zero_step();
        test_back_to_back();
        test_corner_wrap();
        test_random();
        test_reset_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
